// File: rtl/decode_pkg.sv
// Shared definitions for the decode stage: RV opcodes, ALU operation codes
// and the immediate formats the decoder can select between.
package decode_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLTU = 4'd8,
    ALU_SLT  = 4'd9
  } alu_op_t;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_SHAMT
  } imm_fmt_t;

  // alt selects the SUB/SRA variant where funct3 has one
  function automatic alu_op_t alu_from_funct3(input logic [2:0] funct3, input logic alt);
    alu_op_t op;
    case (funct3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/decode_if.sv
// Fetch-to-execute bundle of the decode stage. master drives the fetch inputs
// and the execute ready; slave is the decode stage itself.
interface decode_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);

  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [XLEN-1:0]  in_pc;
  logic             flush;

  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_pc;
  logic [4:0]       out_rd;
  logic [4:0]       out_rs1;
  logic [4:0]       out_rs2;
  logic [XLEN-1:0]  out_imm;
  logic [3:0]       out_alucontrol;
  logic             out_reg_write;
  logic             out_use_imm;
  logic             out_is_branch;
  logic             out_is_load;
  logic             out_is_store;
  logic [2:0]       out_branch_cond;
  logic             out_illegal;
  logic [CNT_W-1:0] perf_count;

  modport master (
    output in_valid, in_instr, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2, out_imm,
           out_alucontrol, out_reg_write, out_use_imm, out_is_branch,
           out_is_load, out_is_store, out_branch_cond, out_illegal, perf_count
  );

  modport slave (
    input  in_valid, in_instr, in_pc, flush, out_ready,
    output in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2, out_imm,
           out_alucontrol, out_reg_write, out_use_imm, out_is_branch,
           out_is_load, out_is_store, out_branch_cond, out_illegal, perf_count
  );

endinterface

// File: rtl/decode_logic.sv
// Purely combinational field decode: ALU control, class flags, illegal-encoding
// detection and sign-extended immediate generation for one instruction word.
module decode_logic
  import decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [XLEN-1:0] imm,
  output alu_op_t         alucontrol,
  output logic            reg_write,
  output logic            use_imm,
  output logic            is_branch,
  output logic            is_load,
  output logic            is_store,
  output logic [2:0]      branch_cond,
  output logic            illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       writes_rd;
  logic       branch_cls;
  logic       load_cls;
  logic       store_cls;
  logic       load_ok;
  logic       store_ok;
  logic       shift_imm;
  imm_fmt_t   fmt;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign rd     = instr[11:7];
  assign rs2    = instr[24:20];

  // Doubleword loads/stores and LWU only exist when XLEN is 64
  assign load_ok   = (funct3 == 3'b011 || funct3 == 3'b110) ? (XLEN == 64) : (funct3 != 3'b111);
  assign store_ok  = (funct3 <= 3'b010) || (XLEN == 64 && funct3 == 3'b011);
  assign shift_imm = (funct3 == 3'b001) || (funct3 == 3'b101);

  always_comb begin
    alucontrol  = ALU_ADD;
    use_imm     = 1'b0;
    writes_rd   = 1'b0;
    branch_cls  = 1'b0;
    load_cls    = 1'b0;
    store_cls   = 1'b0;
    illegal     = 1'b0;
    fmt         = IMM_NONE;
    rs1         = instr[19:15];
    case (opcode)
      OP_R: begin
        writes_rd  = 1'b1;
        alucontrol = alu_from_funct3(funct3, instr[30]);
        if (!(funct7 == 7'h00 ||
              (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101))))
          illegal = 1'b1;
      end
      OP_IMM: begin
        // instr[30] is part of the immediate for everything except SRAI
        writes_rd  = 1'b1;
        use_imm    = 1'b1;
        alucontrol = alu_from_funct3(funct3, instr[30] && funct3 == 3'b101);
        fmt        = shift_imm ? IMM_SHAMT : IMM_I;
      end
      OP_LOAD: begin
        writes_rd = 1'b1;
        load_cls  = 1'b1;
        use_imm   = 1'b1;
        fmt       = IMM_I;
        illegal   = !load_ok;
      end
      OP_STORE: begin
        store_cls = 1'b1;
        use_imm   = 1'b1;
        fmt       = IMM_S;
        illegal   = !store_ok;
      end
      OP_BRANCH: begin
        branch_cls = 1'b1;
        fmt        = IMM_B;
        case (funct3[2:1])
          2'b00:   alucontrol = ALU_SUB;
          2'b10:   alucontrol = ALU_SLT;
          2'b11:   alucontrol = ALU_SLTU;
          default: illegal    = 1'b1;
        endcase
      end
      OP_LUI: begin
        writes_rd = 1'b1;
        use_imm   = 1'b1;
        fmt       = IMM_U;
        rs1       = 5'd0;
      end
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    imm = '0;
    case (fmt)
      IMM_I:     imm = XLEN'($signed(instr[31:20]));
      IMM_S:     imm = XLEN'($signed({instr[31:25], instr[11:7]}));
      IMM_B:     imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
      IMM_U:     imm = XLEN'($signed({instr[31:12], 12'b0}));
      IMM_SHAMT: imm = XLEN'(instr[24:20]);
      default:   imm = '0;
    endcase
  end

  // An illegal bundle must never cause side effects downstream
  assign reg_write   = writes_rd && (rd != 5'd0) && !illegal;
  assign is_branch   = branch_cls && !illegal;
  assign is_load     = load_cls && !illegal;
  assign is_store    = store_cls && !illegal;
  assign branch_cond = funct3;

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: one-deep output register with valid/ready on both
// sides, flush, and a counter of completed output handshakes.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input logic     clk,
  input logic     rst_n,
  decode_if.slave bus
);

  logic [4:0]       d_rd;
  logic [4:0]       d_rs1;
  logic [4:0]       d_rs2;
  logic [XLEN-1:0]  d_imm;
  alu_op_t          d_alu;
  logic             d_reg_write;
  logic             d_use_imm;
  logic             d_is_branch;
  logic             d_is_load;
  logic             d_is_store;
  logic [2:0]       d_branch_cond;
  logic             d_illegal;

  logic             valid_q;
  logic [XLEN-1:0]  pc_q;
  logic [4:0]       rd_q;
  logic [4:0]       rs1_q;
  logic [4:0]       rs2_q;
  logic [XLEN-1:0]  imm_q;
  alu_op_t          alu_q;
  logic             reg_write_q;
  logic             use_imm_q;
  logic             is_branch_q;
  logic             is_load_q;
  logic             is_store_q;
  logic [2:0]       branch_cond_q;
  logic             illegal_q;
  logic [CNT_W-1:0] perf_q;
  logic             in_ready;
  logic             accept;

  decode_logic #(.XLEN(XLEN)) u_logic (
    .instr       (bus.in_instr),
    .rd          (d_rd),
    .rs1         (d_rs1),
    .rs2         (d_rs2),
    .imm         (d_imm),
    .alucontrol  (d_alu),
    .reg_write   (d_reg_write),
    .use_imm     (d_use_imm),
    .is_branch   (d_is_branch),
    .is_load     (d_is_load),
    .is_store    (d_is_store),
    .branch_cond (d_branch_cond),
    .illegal     (d_illegal)
  );

  // The register can be refilled in the same cycle it is drained
  assign in_ready = !bus.flush && (!valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q       <= 1'b0;
      pc_q          <= '0;
      rd_q          <= '0;
      rs1_q         <= '0;
      rs2_q         <= '0;
      imm_q         <= '0;
      alu_q         <= ALU_ADD;
      reg_write_q   <= 1'b0;
      use_imm_q     <= 1'b0;
      is_branch_q   <= 1'b0;
      is_load_q     <= 1'b0;
      is_store_q    <= 1'b0;
      branch_cond_q <= '0;
      illegal_q     <= 1'b0;
      perf_q        <= '0;
    end else begin
      if (bus.flush) begin
        valid_q <= 1'b0;
      end else if (accept) begin
        valid_q       <= 1'b1;
        pc_q          <= bus.in_pc;
        rd_q          <= d_rd;
        rs1_q         <= d_rs1;
        rs2_q         <= d_rs2;
        imm_q         <= d_imm;
        alu_q         <= d_alu;
        reg_write_q   <= d_reg_write;
        use_imm_q     <= d_use_imm;
        is_branch_q   <= d_is_branch;
        is_load_q     <= d_is_load;
        is_store_q    <= d_is_store;
        branch_cond_q <= d_branch_cond;
        illegal_q     <= d_illegal;
      end else if (bus.out_ready) begin
        valid_q <= 1'b0;
      end
      // A handshake that coincides with flush is discarded, so not counted
      if (valid_q && bus.out_ready && !bus.flush)
        perf_q <= perf_q + CNT_W'(1);
    end
  end

  assign bus.in_ready        = in_ready;
  assign bus.out_valid       = valid_q;
  assign bus.out_pc          = pc_q;
  assign bus.out_rd          = rd_q;
  assign bus.out_rs1         = rs1_q;
  assign bus.out_rs2         = rs2_q;
  assign bus.out_imm         = imm_q;
  assign bus.out_alucontrol  = alu_q;
  assign bus.out_reg_write   = reg_write_q;
  assign bus.out_use_imm     = use_imm_q;
  assign bus.out_is_branch   = is_branch_q;
  assign bus.out_is_load     = is_load_q;
  assign bus.out_is_store    = is_store_q;
  assign bus.out_branch_cond = branch_cond_q;
  assign bus.out_illegal     = illegal_q;
  assign bus.perf_count      = perf_q;

endmodule

// File: tb/tb_decode_stage.sv
// Randomized scoreboard bench for decode_stage: accepted instructions are
// decoded by an arithmetic reference model and checked when they leave the stage.
module tb_decode_stage;

  localparam int XLEN  = 32;
  localparam int CNT_W = 32;

  typedef struct {
    logic [XLEN-1:0] pc;
    logic            illegal, reg_write, use_imm, is_branch, is_load, is_store;
    logic [3:0]      alu;
    logic [2:0]      cond;
    logic [4:0]      rd, rs1, rs2;
    logic [XLEN-1:0] imm;
    bit              chk_rs2, chk_imm;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   failures = 0;
  exp_t sb[$];
  bit   exp_valid = 1'b0;
  logic [CNT_W-1:0] exp_count = '0;

  // ALU code by funct3 for R/OP-IMM (non-alternate) and for branches
  int alu_by_f3 [8] = '{0, 5, 9, 8, 4, 6, 3, 2};
  int br_alu    [8] = '{1, 1, 0, 0, 9, 9, 8, 8};

  decode_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

  decode_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [XLEN-1:0] pc);
    exp_t   e;
    int     op = int'(ins[6:0]);
    int     f3 = int'(ins[14:12]);
    int     f7 = int'(ins[31:25]);
    longint v = 0;
    bit     writes = 1'b0;
    e = '{default: '0};
    e.pc  = pc;
    e.rd  = ins[11:7];
    e.rs1 = ins[19:15];
    e.rs2 = ins[24:20];
    case (op)
      'h33: begin
        writes = 1'b1;
        e.chk_rs2 = 1'b1;
        if (f7 == 0) e.alu = 4'(alu_by_f3[f3]);
        else if (f7 == 'h20 && f3 == 0) e.alu = 4'd1;
        else if (f7 == 'h20 && f3 == 5) e.alu = 4'd7;
        else e.illegal = 1'b1;
      end
      'h13: begin
        writes = 1'b1;
        e.use_imm = 1'b1;
        e.chk_imm = 1'b1;
        if (f3 == 1 || f3 == 5) begin
          v = longint'(ins[24:20]);
          e.alu = (f3 == 5 && ins[30]) ? 4'd7 : 4'(alu_by_f3[f3]);
        end else begin
          v = longint'(ins[31:20]);
          if (v >= 2048) v -= 4096;
          e.alu = 4'(alu_by_f3[f3]);
        end
      end
      'h03: begin
        e.use_imm = 1'b1;
        e.chk_imm = 1'b1;
        v = longint'(ins[31:20]);
        if (v >= 2048) v -= 4096;
        if (f3 == 3 || f3 == 6 || f3 == 7) e.illegal = 1'b1;
        else begin e.is_load = 1'b1; writes = 1'b1; end
      end
      'h23: begin
        e.use_imm = 1'b1;
        e.chk_imm = 1'b1;
        e.chk_rs2 = 1'b1;
        v = longint'(ins[31:25]) * 32 + longint'(ins[11:7]);
        if (v >= 2048) v -= 4096;
        if (f3 >= 3) e.illegal = 1'b1;
        else e.is_store = 1'b1;
      end
      'h63: begin
        e.chk_imm = 1'b1;
        e.chk_rs2 = 1'b1;
        v = longint'(ins[11:8]) * 2 + longint'(ins[30:25]) * 32
          + longint'(ins[7]) * 2048 - longint'(ins[31]) * 4096;
        if (f3 == 2 || f3 == 3) e.illegal = 1'b1;
        else begin e.is_branch = 1'b1; e.alu = 4'(br_alu[f3]); e.cond = 3'(f3); end
      end
      'h37: begin
        writes = 1'b1;
        e.use_imm = 1'b1;
        e.chk_imm = 1'b1;
        e.rs1 = 5'd0;
        v = longint'(ins[31:12]) * 4096;
        if (ins[31]) v -= 64'sh1_0000_0000;
      end
      default: e.illegal = 1'b1;
    endcase
    if (e.illegal) writes = 1'b0;
    e.reg_write = writes && (ins[11:7] != 5'd0);
    e.imm = XLEN'(v);
    return e;
  endfunction

  function automatic logic [31:0] randInstr();
    logic [6:0]  ops [7] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h00};
    logic [31:0] r = $urandom();
    int          k = $urandom_range(0, 6);
    if (k == 6) r[6:0] = 7'($urandom());
    else r[6:0] = ops[k];
    if (k == 0)
      r[31:25] = ($urandom_range(0, 3) == 0) ? 7'($urandom()) :
                 (($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00);
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    check("out_pc", bus.out_pc, e.pc);
    check("out_illegal", bus.out_illegal, e.illegal);
    check("out_reg_write", bus.out_reg_write, e.reg_write);
    check("out_is_branch", bus.out_is_branch, e.is_branch);
    check("out_is_load", bus.out_is_load, e.is_load);
    check("out_is_store", bus.out_is_store, e.is_store);
    if (!e.illegal) begin
      check("out_alucontrol", bus.out_alucontrol, e.alu);
      check("out_use_imm", bus.out_use_imm, e.use_imm);
      check("out_rd", bus.out_rd, e.rd);
      check("out_rs1", bus.out_rs1, e.rs1);
      if (e.chk_rs2) check("out_rs2", bus.out_rs2, e.rs2);
      if (e.chk_imm) check("out_imm", bus.out_imm, e.imm);
      if (e.is_branch) check("out_branch_cond", bus.out_branch_cond, e.cond);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] instr, input logic [XLEN-1:0] pc,
                               input bit valid, input bit ready, input bit fl);
    @(posedge clk);
    #1;
    bus.in_instr  = instr;
    bus.in_pc     = pc;
    bus.in_valid  = valid;
    bus.out_ready = ready;
    bus.flush     = fl;
  endtask

  // Monitor: decisions for the coming edge are taken mid-cycle
  always @(negedge clk) begin
    bit accept;
    if (!rst_n) begin
      exp_valid = 1'b0;
      exp_count = '0;
      sb.delete();
    end else begin
      check("out_valid", bus.out_valid, exp_valid);
      check("in_ready", bus.in_ready, !bus.flush && (!exp_valid || bus.out_ready));
      check("perf_count", bus.perf_count, exp_count);
      if (exp_valid) begin
        if (sb.size() == 0) begin
          check("scoreboard_empty", 64'd0, 64'd1);
        end else if (bus.flush) begin
          void'(sb.pop_front());
        end else if (bus.out_ready) begin
          checkOutput(sb.pop_front());
          exp_count = exp_count + 1'b1;
        end else begin
          checkOutput(sb[0]);
        end
      end
      accept = bus.in_valid && !bus.flush && (!exp_valid || bus.out_ready);
      if (accept) sb.push_back(ref_decode(bus.in_instr, bus.in_pc));
      exp_valid = bus.flush ? 1'b0 : (accept ? 1'b1 : (bus.out_ready ? 1'b0 : exp_valid));
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] stream [4] = '{32'h002081B3, 32'hFFF00293, 32'h00208463, 32'h123450B7};
    logic [31:0] cur = '0;
    logic [XLEN-1:0] pc_r = 32'h2000;
    bit pending = 1'b0;
    int idx;
    int cyc;

    bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_pc = '0;
    bus.flush = 1'b0; bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_perf", bus.perf_count, 0);
    check("reset_imm", bus.out_imm, 0);
    check("reset_rd", bus.out_rd, 0);
    check("reset_alu", bus.out_alucontrol, 0);
    check("reset_pc", bus.out_pc, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", bus.in_ready, 1);

    applyStimulus(32'h002081B3, 32'h100, 1, 1, 0);
    applyStimulus(32'hFFF00293, 32'h104, 1, 1, 0);
    applyStimulus(32'h4032D293, 32'h108, 1, 1, 0);
    applyStimulus(32'h00208463, 32'h10C, 1, 1, 0);
    applyStimulus(32'h123450B7, 32'h110, 1, 1, 0);
    applyStimulus(32'h0, 32'h0, 0, 1, 0);

    idx = 0;
    cyc = 0;
    while (idx < 4 && cyc < 20) begin
      applyStimulus(stream[idx], 32'h200 + 32'(idx * 4), 1, !(cyc >= 1 && cyc <= 3), 0);
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) idx++;
      cyc++;
    end
    check("stream_delivered", idx, 4);
    applyStimulus(32'h0, 32'h0, 0, 1, 0);
    applyStimulus(32'h0, 32'h0, 0, 1, 0);

    applyStimulus(32'h00208033, 32'h300, 1, 0, 0);
    applyStimulus(32'h0, 32'h0, 0, 1, 1);
    applyStimulus(32'h0000007F, 32'h304, 1, 1, 0);
    applyStimulus(32'h00208033, 32'h308, 1, 1, 0);
    applyStimulus(32'h0, 32'h0, 0, 1, 0);

    for (int i = 0; i < 300; i++) begin
      if (!pending) begin
        cur = randInstr();
        pc_r = pc_r + 4;
        pending = 1'b1;
      end
      applyStimulus(cur, pc_r, $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 7,
                    $urandom_range(0, 24) == 0);
      rst_n = (i != 150);
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) pending = 1'b0;
    end

    applyStimulus(32'h0, 32'h0, 0, 1, 0);
    rst_n = 1'b1;
    cyc = 0;
    while ((sb.size() != 0 || exp_valid) && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("drain_done", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered RV32I/RV64I instruction decode stage with valid/ready handshake on both sides, sitting between fetch and execute. It generalises the combinational ALU-control decoder:
- parametrised data width;
- full opcode coverage (R, I, load, store, branch, LUI);
- immediate generation, illegal-instruction flagging and pipeline flush;
- a handshake counter for performance monitoring.

## Interface
- XLEN, 32: data/PC width (32 or 64); immediates sign-extended to XLEN.
- CNT_W, 32: width of decoded-instruction counter.
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  fetch presents instruction.
- in_ready  out  1  stage can accept; = !flush && (!out_valid || out_ready).
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  instruction PC.
- flush  in  1  discard held and incoming instruction.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  execute accepts bundle.
- out_pc  out  XLEN  registered PC.
- out_rd, out_rs1, out_rs2  out  5 each  register indices.
- out_imm  out  XLEN  sign-extended immediate.
- out_alucontrol  out  4  ALU op code.
- out_reg_write  out  1  write rd.
- out_use_imm  out  1  ALU operand B = imm.
- out_is_branch, out_is_load, out_is_store  out  1 each  class flags.
- out_branch_cond  out  3  funct3 of branch.
- out_illegal  out  1  unsupported encoding.
- perf_count  out  CNT_W  completed output handshakes.

## Operation
- ALU codes: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLL 5, SRL 6, SRA 7, SLTU 8, SLT 9.
- funct3 map (R and OP-IMM): 000 ADD, 100 XOR, 110 OR, 111 AND, 001 SLL, 101 SRL/SRA, 010 SLT, 011 SLTU.
- R-type: instr[30]=1 selects SUB (funct3 000) or SRA (funct3 101).
- OP-IMM: instr[30] is honoured only for shifts. ADDI ignores instr[30], regardless of immediate value.
- Shift immediate: out_imm = zero-extended shamt (instr[24:20]).
- Load and store: ALU ADD, use_imm=1, I-type and S-type immediate respectively.
- Branch ALU code: BEQ/BNE → SUB; BLT/BGE → SLT; BLTU/BGEU → SLTU. use_imm=0; B-type immediate; out_branch_cond = funct3.
- LUI: ALU ADD, out_rs1=0, use_imm=1, imm = {instr[31:12],12'b0} sign-extended.
- out_reg_write = (R | OP-IMM | load | LUI) && rd != 0.
- Illegal cases:
  - unknown opcode;
  - branch funct3 010/011;
  - R-type funct7 not 0x00/0x20, or 0x20 with funct3 not 000/101;
  - load funct3 011/110/111 (XLEN=32);
  - store funct3 ≥ 011 (XLEN=32).
- Illegal bundle: out_illegal=1, reg_write/branch/load/store=0, other fields don't-care. It still flows downstream and is counted.

## Timing
- Latency 1 cycle: bundle registered on edge where in_valid && in_ready.
- Output fields hold stable while out_valid && !out_ready.
- Back-to-back throughput one per cycle when out_ready=1.
- flush: out_valid=0 at next edge. No input accepted that cycle. An output handshake coinciding with flush is not counted.
- perf_count increments on out_valid && out_ready && !flush. It wraps modulo 2^CNT_W.
- Reset (rst_n=0 at edge): all outputs registered to 0, perf_count=0. in_ready=1 the cycle after release.
- Reset mid-transfer drops the held bundle; no partial state survives.

## Structure
- Package decode_pkg holds:
  - opcode localparams (0110011, 0010011, 0000011, 0100011, 1100011, 0110111);
  - ALU code enum;
  - immediate-format enum.
- Sub-module decode_logic holds the purely combinational field decode and immediate generation. decode_stage adds the handshake register, flush and counter.

## Test plan
- 0x002081B3 (ADD x3,x1,x2) → next cycle out_valid=1, alu 0, rd 3, rs1 1, rs2 2, reg_write 1, use_imm 0.
- 0xFFF00293 (ADDI x5,x0,-1) → alu 0 (not SUB), imm 0xFFFFFFFF, use_imm 1. Then 0x4032D293 (SRAI x5,x5,3) → alu 7, imm 3.
- 0x00208463 (BEQ x1,x2,+8) → is_branch 1, cond 000, alu 1, imm 8, reg_write 0. Then 0x123450B7 (LUI x1) → imm 0x12345000, rs1 0.
- Stream 4 instructions with out_ready low for 3 cycles:
  - in_ready=0 while held, bundle unchanged;
  - all 4 delivered in order;
  - perf_count=4.
- flush with out_valid=1 and out_ready=1 → out_valid=0 next cycle, perf_count unchanged. 0x0000007F → out_illegal 1, reg_write 0. rd=0 ADD → reg_write 0.
